rob_commit_unit: RTL and testbench

- Parametrised reorder buffer with in-order multi-wide commit.
- Accepts one dispatched instruction per cycle and records out-of-order writebacks from EXEC_PORTS execution units.
- Each cycle, retires up to COMMIT_WIDTH of the oldest consecutive executed entries to the register file.
- Successor to the two-wide maximum-tag commit search: commit is by age from a head pointer, not by tag magnitude.

---
 rtl/rob_commit_unit.sv | 128 ++++++++++++
 tb/tb_rob_commit_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// Reorder buffer: single dispatch, EXEC_PORTS out-of-order writebacks, in-order commit of up to COMMIT_WIDTH entries per cycle.
// Define ROB_COMMIT_COUNT_EN to add the 32-bit commit_count retirement counter output.
module rob_commit_unit #(
  parameter  int BUF_SIZE     = 16,
  parameter  int COMMIT_WIDTH = 2,
  parameter  int EXEC_PORTS   = 2,
  parameter  int XLEN         = 32,
  localparam int BUF_SIZE_LOG = $clog2(BUF_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  input  logic [4:0]                   alloc_rd,
  output logic                         alloc_ready,
  output logic [BUF_SIZE_LOG-1:0]      alloc_tag,
  input  logic [EXEC_PORTS-1:0]        wb_valid,
  input  logic [EXEC_PORTS*BUF_SIZE_LOG-1:0] wb_tag,
  input  logic [EXEC_PORTS*XLEN-1:0]   wb_value,
  output logic [COMMIT_WIDTH-1:0]      commit_valid,
  output logic [COMMIT_WIDTH*5-1:0]    commit_rd,
  output logic [COMMIT_WIDTH*XLEN-1:0] commit_value,
  output logic [BUF_SIZE_LOG:0]        count
`ifdef ROB_COMMIT_COUNT_EN
  ,
  output logic [31:0]                  commit_count
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_BUSY, S_EXECUTED} entry_state_e;

  entry_state_e            state_q [BUF_SIZE];
  logic [4:0]              rd_q    [BUF_SIZE];
  logic [XLEN-1:0]         value_q [BUF_SIZE];
  logic [BUF_SIZE_LOG-1:0] head_q, tail_q;
  logic [BUF_SIZE_LOG:0]   count_q;

  logic                    alloc_fire;
  logic [BUF_SIZE_LOG:0]   commit_num;
  logic [BUF_SIZE-1:0]     commit_hit;
  logic [BUF_SIZE-1:0]     wb_take;
  logic [XLEN-1:0]         wb_data [BUF_SIZE];

  assign alloc_ready = (count_q != (BUF_SIZE_LOG+1)'(BUF_SIZE));
  assign alloc_tag   = tail_q;
  assign count       = count_q;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;

  // Commit window: walk from head and stop at the first entry that is not executed.
  always_comb begin
    logic                    run;
    logic [BUF_SIZE_LOG-1:0] idx;
    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    commit_valid = '0;
    commit_rd    = '0;
    commit_value = '0;
    commit_num   = '0;
    commit_hit   = '0;
    run          = !flush;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      idx = head_q + BUF_SIZE_LOG'(k);
      run = run && ((BUF_SIZE_LOG+1)'(k) < count_q) && (state_q[idx] == S_EXECUTED);
      commit_valid[k]                = run;
      commit_rd[k*5 +: 5]            = rd_q[idx];
      commit_value[k*XLEN +: XLEN]   = value_q[idx];
      if (run) begin
        commit_hit[idx] = 1'b1;
        commit_num      = commit_num + (BUF_SIZE_LOG+1)'(1);
      end
    end
  end

  // Ports are scanned high to low so the lowest-numbered port is the last to claim an entry.
  always_comb begin
    for (int i = 0; i < BUF_SIZE; i++) begin
      wb_take[i] = 1'b0;
      wb_data[i] = '0;
      for (int p = EXEC_PORTS-1; p >= 0; p--) begin
        if (wb_valid[p] && (wb_tag[p*BUF_SIZE_LOG +: BUF_SIZE_LOG] == BUF_SIZE_LOG'(i))) begin
          wb_take[i] = 1'b1;
          wb_data[i] = wb_value[p*XLEN +: XLEN];
        end
      end
      wb_take[i] = wb_take[i] && (state_q[i] == S_BUSY) && !flush;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_SIZE; i++) state_q[i] <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < BUF_SIZE; i++) state_q[i] <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        if (commit_hit[i])                                       state_q[i] <= S_EMPTY;
        else if (alloc_fire && (tail_q == BUF_SIZE_LOG'(i)))     state_q[i] <= S_BUSY;
        else if (wb_take[i])                                     state_q[i] <= S_EXECUTED;
      end
      if (alloc_fire) tail_q <= tail_q + BUF_SIZE_LOG'(1);
      head_q  <= head_q + commit_num[BUF_SIZE_LOG-1:0];
      count_q <= count_q + (BUF_SIZE_LOG+1)'(alloc_fire) - commit_num;
    end
  end

  // NOTE: payload storage has no reset; entry state alone decides whether its contents are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (alloc_fire && (tail_q == BUF_SIZE_LOG'(i))) rd_q[i] <= alloc_rd;
      if (wb_take[i])                                 value_q[i] <= wb_data[i];
    end
  end

`ifdef ROB_COMMIT_COUNT_EN
  // Flush forces commit_valid low, so the counter naturally holds across a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) commit_count <= '0;
    else     commit_count <= commit_count + 32'(commit_num);
  end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed testbench for rob_commit_unit (default parameters: 16 entries, 2-wide commit, 2 writeback ports).
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_tag;
  logic [63:0] wb_value;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [63:0] commit_value;
  logic [4:0]  count;
`ifdef ROB_COMMIT_COUNT_EN
  logic [31:0] commit_count;
`endif

  int checks = 0;
  int errors = 0;

  rob_commit_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_value     (wb_value),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .count        (count)
`ifdef ROB_COMMIT_COUNT_EN
    ,
    .commit_count (commit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic [1:0] v, input int t0, input logic [31:0] v0,
                        input int t1, input logic [31:0] v1);
    wb_valid = v;
    wb_tag   = {4'(t1), 4'(t0)};
    wb_value = {v1, v0};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
    wb_set(2'b00, 0, 0, 0, 0);
    #2;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", alloc_ready); end
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit got %b exp 00", commit_valid); end
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", alloc_tag); end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
      #1;
      checks++; if (alloc_tag !== 4'(i)) begin errors++; $display("FAIL basic_tag got %0d exp %0d", alloc_tag, i); end
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
    wb_set(2'b01, 2, 32'h300, 0, 0);
    tick();
    wb_set(2'b11, 0, 32'h100, 1, 32'h200);
    #1;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL basic_tag2_only got %b exp 00", commit_valid); end
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    #1;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL basic_commit2 got %b exp 11", commit_valid); end
    checks++; if (commit_rd !== {5'd2, 5'd1}) begin errors++; $display("FAIL basic_rd2 got %h exp %h", commit_rd, {5'd2, 5'd1}); end
    checks++; if (commit_value !== {32'h200, 32'h100}) begin errors++; $display("FAIL basic_val2 got %h exp %h", commit_value, {32'h200, 32'h100}); end
    tick();
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL basic_commit1 got %b exp 01", commit_valid); end
    checks++; if (commit_rd[4:0] !== 5'd3) begin errors++; $display("FAIL basic_rd1 got %0d exp 3", commit_rd[4:0]); end
    checks++; if (commit_value[31:0] !== 32'h300) begin errors++; $display("FAIL basic_val1 got %h exp 300", commit_value[31:0]); end
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL basic_drain got %0d exp 0", count); end
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL basic_empty got %b exp 00", commit_valid); end
  endtask

  // head and tail start at 3 here
  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i);
      #1;
      checks++; if (alloc_tag !== 4'(3 + i)) begin errors++; $display("FAIL full_tag got %0d exp %0d", alloc_tag, (3 + i) % 16); end
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", alloc_ready); end
    alloc_valid = 1'b1; alloc_rd = 5'd31;
    tick();
    alloc_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_17th got %0d exp 16", count); end
    for (int c = 0; c < 8; c++) begin
      wb_set(2'b11, 3 + 2*c, 32'h1000 + 32'(2*c), 4 + 2*c, 32'h1001 + 32'(2*c));
      alloc_valid = (c == 1);
      tick();
      alloc_valid = 1'b0;
      checks++; if (count !== 5'(16 - 2*c)) begin errors++; $display("FAIL full_drain_count got %0d exp %0d", count, 16 - 2*c); end
      checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL full_commit got %b exp 11", commit_valid); end
      checks++; if (commit_rd !== {5'(2*c + 1), 5'(2*c)}) begin errors++; $display("FAIL full_rd got %h exp %h", commit_rd, {5'(2*c + 1), 5'(2*c)}); end
      checks++; if (commit_value !== {32'h1001 + 32'(2*c), 32'h1000 + 32'(2*c)}) begin errors++; $display("FAIL full_val got %h exp %h", commit_value, {32'h1001 + 32'(2*c), 32'h1000 + 32'(2*c)}); end
    end
    wb_set(2'b00, 0, 0, 0, 0);
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    for (int i = 0; i < 12; i++) tick();
    alloc_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wb_set(2'b11, 3 + 2*c, 0, 4 + 2*c, 0);
      tick();
    end
    wb_set(2'b00, 0, 0, 0, 0);
    tick(); tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_pre_count got %0d exp 0", count); end
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(7 + i);
      #1;
      checks++; if (alloc_tag !== 4'(15 + i)) begin errors++; $display("FAIL wrap_tag got %0d exp %0d", alloc_tag, (15 + i) % 16); end
      tick();
    end
    alloc_valid = 1'b0;
    wb_set(2'b11, 1, 32'hB1, 0, 32'hB0);
    tick();
    wb_set(2'b01, 15, 32'hBF, 0, 0);
    #1;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL wrap_hold got %b exp 00", commit_valid); end
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    #1;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL wrap_commit2 got %b exp 11", commit_valid); end
    checks++; if (commit_rd !== {5'd8, 5'd7}) begin errors++; $display("FAIL wrap_rd2 got %h exp %h", commit_rd, {5'd8, 5'd7}); end
    checks++; if (commit_value !== {32'hB0, 32'hBF}) begin errors++; $display("FAIL wrap_val2 got %h exp %h", commit_value, {32'hB0, 32'hBF}); end
    tick();
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL wrap_commit1 got %b exp 01", commit_valid); end
    checks++; if (commit_rd[4:0] !== 5'd9) begin errors++; $display("FAIL wrap_rd1 got %0d exp 9", commit_rd[4:0]); end
    checks++; if (commit_value[31:0] !== 32'hB1) begin errors++; $display("FAIL wrap_val1 got %h exp b1", commit_value[31:0]); end
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", count); end
  endtask

  // head and tail start at 2 here
  task automatic test_same_tag();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(10 + i);
      tick();
    end
    alloc_valid = 1'b0;
    wb_set(2'b11, 4, 32'hAAAA, 4, 32'h5555);
    tick();
    wb_set(2'b11, 4, 32'h1234, 2, 32'h22);
    #1;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL same_hold got %b exp 00", commit_valid); end
    tick();
    wb_set(2'b11, 5, 32'hDEAD, 3, 32'h33);
    #1;
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL same_commit_head got %b exp 01", commit_valid); end
    checks++; if (commit_value[31:0] !== 32'h22) begin errors++; $display("FAIL same_val_head got %h exp 22", commit_value[31:0]); end
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    #1;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL same_empty_wb_count got %0d exp 2", count); end
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL same_commit got %b exp 11", commit_valid); end
    checks++; if (commit_rd !== {5'd12, 5'd11}) begin errors++; $display("FAIL same_rd got %h exp %h", commit_rd, {5'd12, 5'd11}); end
    checks++; if (commit_value !== {32'hAAAA, 32'h33}) begin errors++; $display("FAIL same_port_priority got %h exp %h", commit_value, {32'hAAAA, 32'h33}); end
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL same_drain got %0d exp 0", count); end
    checks++; if (alloc_tag !== 4'd5) begin errors++; $display("FAIL same_tail got %0d exp 5", alloc_tag); end
  endtask

  // head and tail start at 5 here
  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(1 + i);
      tick();
    end
    alloc_valid = 1'b0;
    wb_set(2'b11, 9, 1, 8, 1);
    tick();
    wb_set(2'b11, 7, 1, 6, 1);
    tick();
    wb_set(2'b01, 5, 1, 0, 0);
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    #1;
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL flush_pre_commit got %b exp 11", commit_valid); end
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", count); end
    flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd30;
    #1;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL flush_commit_gate got %b exp 00", commit_valid); end
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL flush_tail got %0d exp 0", alloc_tag); end
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL flush_post_commit got %b exp 00", commit_valid); end
  endtask

  // Allocation and commit in the same cycle; also confirms head restarted at 0 after flush.
  task automatic test_back_to_back();
    alloc_valid = 1'b1; alloc_rd = 5'd20;
    tick();
    alloc_valid = 1'b0;
    wb_set(2'b01, 0, 32'h77, 0, 0);
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    #1;
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL b2b_commit got %b exp 01", commit_valid); end
    checks++; if (commit_rd[4:0] !== 5'd20) begin errors++; $display("FAIL b2b_rd got %0d exp 20", commit_rd[4:0]); end
    checks++; if (commit_value[31:0] !== 32'h77) begin errors++; $display("FAIL b2b_val got %h exp 77", commit_value[31:0]); end
    alloc_valid = 1'b1; alloc_rd = 5'd21;
    #1;
    checks++; if (alloc_tag !== 4'd1) begin errors++; $display("FAIL b2b_tag got %0d exp 1", alloc_tag); end
    tick();
    alloc_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL b2b_count got %0d exp 1", count); end
    checks++; if (alloc_tag !== 4'd2) begin errors++; $display("FAIL b2b_tail got %0d exp 2", alloc_tag); end
    wb_set(2'b01, 1, 32'h88, 0, 0);
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    #1;
    checks++; if (commit_rd[4:0] !== 5'd21 || commit_valid !== 2'b01) begin errors++; $display("FAIL b2b_second got %b/%0d exp 01/21", commit_valid, commit_rd[4:0]); end
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", count); end
  endtask

  // head and tail start at 2 here
  task automatic test_async_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd1;
    for (int i = 0; i < 7; i++) tick();
    alloc_valid = 1'b0;
    wb_set(2'b11, 2, 1, 3, 2);
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    #1;
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL arst_pre_count got %0d exp 7", count); end
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL arst_pre_commit got %b exp 11", commit_valid); end
`ifdef ROB_COMMIT_COUNT_EN
    checks++; if (commit_count !== 32'd39) begin errors++; $display("FAIL cnt_total got %0d exp 39", commit_count); end
`endif
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %0b exp 1", alloc_ready); end
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL arst_commit got %b exp 00", commit_valid); end
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL arst_tag got %0d exp 0", alloc_tag); end
`ifdef ROB_COMMIT_COUNT_EN
    checks++; if (commit_count !== 32'd0) begin errors++; $display("FAIL cnt_reset got %0d exp 0", commit_count); end
`endif
    #2 rst = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd4;
    tick();
    alloc_valid = 1'b0;
    wb_set(2'b01, 0, 32'h9, 0, 0);
    tick();
    wb_set(2'b00, 0, 0, 0, 0);
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL arst_post_count got %0d exp 0", count); end
`ifdef ROB_COMMIT_COUNT_EN
    checks++; if (commit_count !== 32'd1) begin errors++; $display("FAIL cnt_one got %0d exp 1", commit_count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (commit_count !== 32'd1) begin errors++; $display("FAIL cnt_flush got %0d exp 1", commit_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_same_tag();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
